// File: rtl/unary_stream_encoder.sv
// unary_stream_encoder: binary magnitude -> fixed-length unary bit stream.
// A magnitude is taken through a valid/ready load handshake and then
// serialised as INPUT_WIDTH bits, one per non-stalled cycle, each qualified
// by o_bit_valid. A one-cycle o_done pulse follows the final bit.
// Optional build macro: UNARY_ENC_DITHER_EN selects evenly distributed
// (Bresenham) ones instead of the default thermometer code (ones first).
module unary_stream_encoder #(
  parameter int INPUT_WIDTH = 32,
  parameter int COUNT_WIDTH = $clog2(INPUT_WIDTH + 1)
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_load_valid,
  output logic                   o_load_ready,
  input  logic [COUNT_WIDTH-1:0] i_load_value,
  input  logic                   i_stall,
  output logic                   o_bit_out,
  output logic                   o_bit_valid,
  output logic                   o_busy,
  output logic                   o_done
);

  // Largest representable magnitude and index of the final stream bit.
  localparam logic [COUNT_WIDTH-1:0] LP_MAX_VALUE = COUNT_WIDTH'(INPUT_WIDTH);
  localparam logic [COUNT_WIDTH-1:0] LP_LAST_IDX  = COUNT_WIDTH'(INPUT_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t                 r_state;
  logic [COUNT_WIDTH-1:0] r_value;
  logic [COUNT_WIDTH-1:0] r_count;
  logic                   r_bit_out;
  logic                   r_bit_valid;
  logic                   r_done;

  logic [COUNT_WIDTH-1:0] w_load_sat;
  logic                   w_bit;

  // Out-of-range magnitudes saturate to a stream of all ones.
  assign w_load_sat = (i_load_value > LP_MAX_VALUE) ? LP_MAX_VALUE : i_load_value;

`ifdef UNARY_ENC_DITHER_EN
  // One extra bit of headroom: acc stays below INPUT_WIDTH between bits, and
  // adding a value of at most INPUT_WIDTH cannot exceed 2*INPUT_WIDTH-1.
  localparam logic [COUNT_WIDTH:0] LP_ACC_WRAP = (COUNT_WIDTH + 1)'(INPUT_WIDTH);

  logic [COUNT_WIDTH:0] r_acc;
  logic [COUNT_WIDTH:0] w_acc_sum;
  logic [COUNT_WIDTH:0] w_acc_next;

  assign w_acc_sum  = r_acc + {1'b0, r_value};
  assign w_bit      = (w_acc_sum >= LP_ACC_WRAP);
  assign w_acc_next = w_bit ? (w_acc_sum - LP_ACC_WRAP) : w_acc_sum;

  // Error accumulator: cleared on load, advanced only on emitted bits.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_acc <= '0;
    end else if (r_state == ST_IDLE && i_load_valid) begin
      r_acc <= '0;
    end else if (r_state == ST_STREAM && !i_stall) begin
      r_acc <= w_acc_next;
    end
  end
`else
  // Thermometer code: the first r_value bits are ones, the rest zeros.
  assign w_bit = (r_count < r_value);
`endif

  // Load/stream/done sequencing with registered stream outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_value     <= '0;
      r_count     <= '0;
      r_bit_out   <= 1'b0;
      r_bit_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_bit_valid <= 1'b0;
          r_done      <= 1'b0;
          if (i_load_valid) begin
            r_value <= w_load_sat;
            r_count <= '0;
            r_state <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          r_done <= 1'b0;
          if (i_stall) begin
            // Hold the previous bit; only the qualifier drops.
            r_bit_valid <= 1'b0;
          end else begin
            r_bit_out   <= w_bit;
            r_bit_valid <= 1'b1;
            r_count     <= r_count + COUNT_WIDTH'(1);
            if (r_count == LP_LAST_IDX) begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          // Stall is deliberately ignored here: done always pulses.
          r_bit_valid <= 1'b0;
          r_done      <= 1'b1;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_load_ready = (r_state == ST_IDLE);
  assign o_busy       = (r_state != ST_IDLE);
  assign o_bit_out    = r_bit_out;
  assign o_bit_valid  = r_bit_valid;
  assign o_done       = r_done;

endmodule

// File: tb/tb_unary_stream_encoder.sv
// Self-checking bench for unary_stream_encoder (INPUT_WIDTH = 32).
// A queue-based model predicts every output on every cycle; directed
// streams additionally pin collected bit vectors and latencies to literals.
// Build with UNARY_ENC_DITHER_EN defined to exercise the dithered encoding.
module tb_unary_stream_encoder;

  localparam int IW = 32;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_valid = 1'b0;
  logic [CW-1:0] load_value = '0;
  logic          stall = 1'b0;
  logic          o_load_ready;
  logic          o_bit_out;
  logic          o_bit_valid;
  logic          o_busy;
  logic          o_done;

  unary_stream_encoder #(
    .INPUT_WIDTH (IW),
    .COUNT_WIDTH (CW)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_load_valid (load_valid),
    .o_load_ready (o_load_ready),
    .i_load_value (load_value),
    .i_stall      (stall),
    .o_bit_out    (o_bit_out),
    .o_bit_valid  (o_bit_valid),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  always #5 clk = ~clk;

  // Separate counters for the per-cycle checker and the directed checks.
  int n_cmp_m = 0;
  int n_fail_m = 0;
  int n_cmp_d = 0;
  int n_fail_d = 0;

  task automatic chk_m(input string name, input longint got, input longint want);
    n_cmp_m++;
    if (got != want) begin
      n_fail_m++;
      $display("FAIL %s @%0t: got %0d want %0d", name, $time, got, want);
    end
  endtask

  task automatic chk_d(input string name, input longint got, input longint want);
    n_cmp_d++;
    if (got != want) begin
      n_fail_d++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, got, got, want, want);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Stream bit i for magnitude v, straight from the encoding rules.
  function automatic bit model_bit(input int v, input int i);
`ifdef UNARY_ENC_DITHER_EN
    return (((i + 1) * v) / IW) != ((i * v) / IW);
`else
    return i < v;
`endif
  endfunction

  bit m_q[$];
  bit m_done_due = 1'b0;
  bit exp_bit = 1'b0;
  bit exp_valid = 1'b0;
  bit exp_done = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_done_due = 1'b0;
      exp_bit    = 1'b0;
      exp_valid  = 1'b0;
      exp_done   = 1'b0;
    end else begin
      exp_valid = 1'b0;
      exp_done  = 1'b0;
      if (m_q.size() != 0) begin
        if (!stall) begin
          exp_bit   = m_q.pop_front();
          exp_valid = 1'b1;
          if (m_q.size() == 0) m_done_due = 1'b1;
        end
      end else if (m_done_due) begin
        exp_done   = 1'b1;
        m_done_due = 1'b0;
      end else if (load_valid) begin
        int sat;
        sat = (int'(load_value) > IW) ? IW : int'(load_value);
        for (int i = 0; i < IW; i++) m_q.push_back(model_bit(sat, i));
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk_m("bit_valid", o_bit_valid, exp_valid);
      chk_m("bit_out", o_bit_out, exp_bit);
      chk_m("done", o_done, exp_done);
      chk_m("load_ready", o_load_ready, (m_q.size() == 0 && !m_done_due) ? 1 : 0);
      chk_m("busy", o_busy, (m_q.size() == 0 && !m_done_due) ? 0 : 1);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (o_load_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk_d("wait_idle_timeout", ok, 1);
  endtask

  // Loads v, applies stall on edges whose index (after acceptance) is set in
  // mask, collects the emitted bits and measures edges from load to done.
  task automatic do_stream(input string name, input int v, input logic [63:0] mask,
                           input logic [31:0] exp_vec, input int exp_lat);
    logic [31:0] got_vec;
    int got_n, lat, j, want_ones;
    bit seen;
    wait_idle();
    load_valid = 1'b1;
    load_value = CW'(v);
    stall = 1'b0;
    got_vec = '0;
    got_n = 0;
    seen = 1'b0;
    lat = -1;
    j = 0;
    @(posedge clk);
    while (!seen && j < 100) begin
      @(negedge clk);
      if (o_bit_valid) begin
        if (got_n < IW) got_vec[got_n] = o_bit_out;
        got_n++;
      end
      if (o_done) begin
        seen = 1'b1;
        lat = j;
      end
      load_valid = 1'b0;
      j++;
      stall = (j < 64) ? mask[j] : 1'b0;
    end
    stall = 1'b0;
    want_ones = (v > IW) ? IW : v;
    chk_d({name, "_done_seen"}, seen, 1);
    chk_d({name, "_valid_count"}, got_n, IW);
    chk_d({name, "_vector"}, got_vec, exp_vec);
    chk_d({name, "_ones"}, $countones(got_vec), want_ones);
    chk_d({name, "_latency"}, lat, exp_lat);
    @(negedge clk);
    chk_d({name, "_ready_after_done"}, o_load_ready, 1);
    $display("stream %-10s value=%0d bits=0x%08h ones=%0d latency=%0d", name, v, got_vec,
             $countones(got_vec), lat);
  endtask

  task automatic do_back_to_back();
    int accepts, nv, nd, ones;
    wait_idle();
    load_valid = 1'b1;
    load_value = CW'(9);
    accepts = o_load_ready ? 1 : 0;
    nv = 0;
    nd = 0;
    ones = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (o_bit_valid) begin
        nv++;
        if (o_bit_out) ones++;
      end
      if (o_done) nd++;
      if (accepts == 1 && o_busy) load_value = CW'(2);
      if (accepts == 2) load_valid = 1'b0;
      if (nd == 2) break;
      if (o_load_ready && load_valid) accepts++;
    end
    load_valid = 1'b0;
    chk_d("b2b_accepts", accepts, 2);
    chk_d("b2b_valid_cycles", nv, 64);
    chk_d("b2b_done_pulses", nd, 2);
    chk_d("b2b_ones", ones, 11);
    $display("stream b2b        values=9,2 valid=%0d done=%0d ones=%0d", nv, nd, ones);
  endtask

  task automatic do_reset_abort();
    int seen_bits, nv, nd;
    wait_idle();
    load_valid = 1'b1;
    load_value = CW'(20);
    @(posedge clk);
    seen_bits = 0;
    for (int k = 0; k < 60 && seen_bits < 17; k++) begin
      @(negedge clk);
      load_valid = 1'b0;
      if (o_bit_valid) seen_bits++;
    end
    chk_d("abort_reached_bit17", seen_bits, 17);
    #2 rst = 1'b1;
    #1;
    chk_d("abort_bit_out", o_bit_out, 0);
    chk_d("abort_bit_valid", o_bit_valid, 0);
    chk_d("abort_done", o_done, 0);
    chk_d("abort_busy", o_busy, 0);
    chk_d("abort_load_ready", o_load_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    nv = 0;
    nd = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (o_bit_valid) nv++;
      if (o_done) nd++;
    end
    chk_d("abort_no_bits", nv, 0);
    chk_d("abort_no_done", nd, 0);
    $display("abort   value=20 after %0d bits: valid=%0d done=%0d afterwards", seen_bits, nv, nd);
  endtask

  // Expected vectors per build (bit i of the vector = stream bit i).
  logic [31:0] v5, v12, v7, v3, v8, v16;

  initial begin
`ifdef UNARY_ENC_DITHER_EN
    v5  = 32'h8208_1040;
    v12 = 32'hA4A4_A4A4;
    v7  = 32'h8844_2210;
    v3  = 32'h8020_0400;
    v8  = 32'h8888_8888;
    v16 = 32'hAAAA_AAAA;
`else
    v5  = 32'h0000_001F;
    v12 = 32'h0000_0FFF;
    v7  = 32'h0000_007F;
    v3  = 32'h0000_0007;
    v8  = 32'h0000_00FF;
    v16 = 32'h0000_FFFF;
`endif
    #1;
    chk_d("reset_bit_out", o_bit_out, 0);
    chk_d("reset_bit_valid", o_bit_valid, 0);
    chk_d("reset_done", o_done, 0);
    chk_d("reset_busy", o_busy, 0);
    chk_d("reset_load_ready", o_load_ready, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    do_stream("load5", 5, 64'd0, v5, 33);
    do_stream("load0", 0, 64'd0, 32'h0000_0000, 33);
    do_stream("load32", 32, 64'd0, 32'hFFFF_FFFF, 33);
    do_stream("load40", 40, 64'd0, 32'hFFFF_FFFF, 33);
    do_stream("stall12", 12, (64'd1 << 3) | (64'd1 << 4) | (64'd1 << 5) | (64'd1 << 6) | (64'd1 << 10),
              v12, 38);
    do_stream("donestall", 7, 64'd1 << 33, v7, 33);
    do_reset_abort();
    do_stream("after_rst", 3, 64'd0, v3, 33);
    do_back_to_back();
    do_stream("load8", 8, 64'd0, v8, 33);
    do_stream("load16", 16, 64'd0, v16, 33);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp_m + n_cmp_d,
             n_fail_m + n_fail_d);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/unary_stream_encoder.md
Name: unary_stream_encoder

Overview:
- Binary-to-unary front end for the unary arithmetic units, e.g. the unary multiplier.
- Accepts a binary magnitude through a valid/ready load handshake.
- Serialises the magnitude into a fixed-length INPUT_WIDTH-bit stream, emitting one bit per enabled cycle with a qualifying valid strobe.
- One instance drives each multiplier operand: bit_out feeds the operand bit, bit_valid feeds that operand's ready lane.

Parameters:
- INPUT_WIDTH, 32, stream length in bits; also the maximum representable magnitude.
- COUNT_WIDTH, $clog2(INPUT_WIDTH+1), width of the magnitude and of the internal counters.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- load_valid  input  1  load_value is valid this cycle.
- load_ready  output  1  encoder idle and able to accept a load.
- load_value  input  COUNT_WIDTH  magnitude to encode, range 0..INPUT_WIDTH.
- stall  input  1  downstream hold; suppresses emission on this edge.
- bit_out  output  1  current stream bit.
- bit_valid  output  1  bit_out carries a new stream bit this cycle.
- busy  output  1  stream in progress (STREAM or DONE state).
- done  output  1  one-cycle pulse after the final stream bit.

Behaviour:
- Reset (async, active-high) forces:
  - state IDLE
  - bit_out=0, bit_valid=0, done=0
  - emit count=0, stored value=0, accumulator=0
- Reset asserted mid-stream aborts the stream immediately; no done pulse is produced.
- States are IDLE, STREAM and DONE.
  - load_ready = (state==IDLE), combinational.
  - busy = (state!=IDLE), combinational.
- IDLE:
  - On an edge with load_valid && load_ready, capture value = min(load_value, INPUT_WIDTH).
  - On that same edge, clear emit count and accumulator, and go to STREAM.
  - load_valid while not load_ready is ignored; nothing is captured.
- STREAM, on each edge:
  - stall=0: register bit_out = encoded bit, bit_valid<=1, emit count += 1.
  - stall=1: bit_valid<=0, bit_out holds its previous value, count unchanged.
  - The edge that registers bit number INPUT_WIDTH moves the state to DONE.
- DONE:
  - Next edge: bit_valid<=0, done<=1 for exactly one cycle, state goes to IDLE.
  - done is high in the cycle directly after the last bit_valid cycle. load_ready is high in the cycle after that.
- Default encoding is thermometer: bit = (emit count < value), i.e. ones first, then zeros.
- Stream invariants:
  - Exactly INPUT_WIDTH bit_valid cycles per accepted load.
  - Number of 1 bits equals value.
- Latency: load accepted on edge E0, first bit_valid high after E1 (assuming no stall).
- Boundaries:
  - value=0 gives all zeros.
  - value=INPUT_WIDTH gives all ones.
  - load_value>INPUT_WIDTH saturates to INPUT_WIDTH.
  - stall held in DONE has no effect; done still pulses.
  - Emit count never wraps, because the state leaves STREAM at INPUT_WIDTH.

Optional Feature:
- Macro: UNARY_ENC_DITHER_EN.
- Defined: thermometer encoding is replaced by evenly distributed (Bresenham) encoding.
  - Accumulator width is COUNT_WIDTH+1.
  - Per emitted bit: acc += value; if acc >= INPUT_WIDTH then bit=1 and acc -= INPUT_WIDTH, else bit=0.
  - After k emitted bits the ones count equals floor(k*value/INPUT_WIDTH).
  - Total ones is exactly value.
  - Stalled edges leave acc unchanged.
- Undefined: thermometer encoding; the accumulator is not instantiated.
- Handshake, timing and done behaviour are identical in both builds.

Test Plan:
- Load 5, stall=0 -> 32 consecutive bit_valid cycles; bits 1,1,1,1,1 then 27 zeros. done pulses one cycle after the last bit; load_ready is high the cycle after done.
- Load 0 and load 32 -> 32 zeros and 32 ones respectively. Load 40 -> saturated, 32 ones.
- Load 12, stall high on cycles 3-6 and 10 -> bit_valid low on those cycles, bit_out held, stream completes 5 cycles late, 12 ones total.
- Reset asserted at bit 17 of a 20-value stream -> all outputs 0 asynchronously, no done pulse. A new load of 3 afterwards streams 3 ones correctly.
- load_valid held high throughout two back-to-back streams -> the second load is captured only in IDLE. Exactly 64 bit_valid cycles and 2 done pulses result.
- UNARY_ENC_DITHER_EN, load 8 -> a 1 on every 4th emitted bit (bits 3, 7, 11, ...), 8 ones total. Load 16 -> alternating 0,1.
